// File: rtl/lane_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_pkg
// Description : Shared sizes, state encoding and lane-index wrap helper for
//               the lane return path.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_pkg;

    localparam int LANES = 4;
    localparam int DW    = 1;
    localparam int SEL_W = $clog2(LANES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Operand is one bit wider than a lane index so ptr+offset cannot overflow.
    function automatic logic [SEL_W-1:0] lane_wrap(input logic [SEL_W:0] v);
        logic [SEL_W:0] m;
        m = v % (SEL_W+1)'(LANES);
        return m[SEL_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : lane_collector_if
// Description : Lane inputs, merged output handshake and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface lane_collector_if;
    import lane_pkg::*;

    logic [LANES-1:0]    lane_vld;
    logic [LANES*DW-1:0] lane_data;
    logic                out_vld;
    logic                out_rdy;
    logic [SEL_W-1:0]    out_sel;
    logic [DW-1:0]       out_data;
    logic [LANES-1:0]    pend;
    logic [LANES-1:0]    ovf;
    logic                ovf_clr;

    modport master (
        output lane_vld, lane_data, out_rdy, ovf_clr,
        input  out_vld, out_sel, out_data, pend, ovf
    );

    modport slave (
        input  lane_vld, lane_data, out_rdy, ovf_clr,
        output out_vld, out_sel, out_data, pend, ovf
    );

endinterface
`default_nettype wire

// File: rtl/rr_lane_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_lane_pick
// Description : Combinational round-robin pick over pending lanes, starting
//               at ptr and wrapping to lane 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_lane_pick
    import lane_pkg::*;
(
    input  wire logic [LANES-1:0] pend,
    input  wire logic [SEL_W-1:0] ptr,
    output logic                  found,
    output logic [SEL_W-1:0]      g
);

    // Scan from farthest to nearest so the closest pending lane to ptr wins.
    always_comb begin
        logic [SEL_W-1:0] w_idx;
        found = 1'b0;
        g     = '0;
        w_idx = '0;
        for (int k = LANES-1; k >= 0; k--) begin
            w_idx = lane_wrap({1'b0, ptr} + (SEL_W+1)'(k));
            if (pend[w_idx]) begin
                found = 1'b1;
                g     = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_collector.sv
`default_nettype none
// ============================================================================
// Module      : lane_collector
// Description : Buffers one result per lane, arbitrates round-robin and
//               presents results with their lane index under valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_collector
    import lane_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    lane_collector_if.slave    bus
);

    state_t             r_state;
    state_t             w_state_nx;
    logic [SEL_W-1:0]   r_ptr;
    logic [DW-1:0]      r_buf [LANES];
    logic [LANES-1:0]   r_pend;
    logic [LANES-1:0]   r_ovf;
    logic [SEL_W-1:0]   r_out_sel;
    logic [DW-1:0]      r_out_data;

    logic               w_found;
    logic [SEL_W-1:0]   w_g;
    logic               w_take;
    logic [LANES-1:0]   w_pop;
    logic [LANES-1:0]   w_cap;
    logic [LANES-1:0]   w_ovf_set;

    rr_lane_pick u_pick (
        .pend  (r_pend),
        .ptr   (r_ptr),
        .found (w_found),
        .g     (w_g)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_take     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_take     = 1'b1;
                    w_state_nx = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_rdy) begin
                    if (w_found) w_take     = 1'b1;
                    else         w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_pop = '0;
        if (w_take) w_pop[w_g] = 1'b1;
    end

    // A lane popped this cycle can accept a new result without overflowing.
    always_comb begin
        w_cap     = '0;
        w_ovf_set = '0;
        for (int i = 0; i < LANES; i++) begin
            w_cap[i]     = bus.lane_vld[i] & (~r_pend[i] | w_pop[i]);
            w_ovf_set[i] = bus.lane_vld[i] &   r_pend[i] & ~w_pop[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_pend     <= '0;
            r_ovf      <= '0;
            r_out_sel  <= '0;
            r_out_data <= '0;
            for (int i = 0; i < LANES; i++) r_buf[i] <= '0;
        end else begin
            r_pend <= w_cap | (r_pend & ~w_pop);
            r_ovf  <= (r_ovf & ~{LANES{bus.ovf_clr}}) | w_ovf_set;
            if (w_take) begin
                r_out_sel  <= w_g;
                r_out_data <= r_buf[w_g];
                r_ptr      <= lane_wrap({1'b0, w_g} + (SEL_W+1)'(1));
            end
            for (int i = 0; i < LANES; i++) begin
                if (w_cap[i]) r_buf[i] <= bus.lane_data[i*DW +: DW];
            end
        end
    end

    assign bus.out_vld  = (r_state == HOLD);
    assign bus.out_sel  = r_out_sel;
    assign bus.out_data = r_out_data;
    assign bus.pend     = r_pend;
    assign bus.ovf      = r_ovf;

endmodule
`default_nettype wire
